// File: rtl/dz_tx_scan.sv
// DZ11 transmitter scanner: round-robins the lines for one that is enabled and has an
// empty UART transmitter, offers it to the CSR, and forwards TDR low-byte writes to it.
//
// state | meaning
// SCAN  | divider running; one candidate line examined per terminal count
// READY | csrTRDY=1, csrTLINE names the line awaiting a TDR byte
// LOAD  | one-cycle load strobe to the selected UART, then resume after that line
module dz_tx_scan #(
    parameter int NLINES   = 8,
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              devRESET,
    input  logic              csrCLR,
    input  logic              csrMSE,
    input  logic [NLINES-1:0] tcrLIN,
    input  logic [NLINES-1:0] uartTXEMPTY,
    input  logic              tdrWRITE,
    input  logic              devLOBYTE,
    input  logic [7:0]        dzDATAI,
    output logic              csrTRDY,
    output logic [2:0]        csrTLINE,
    output logic [NLINES-1:0] uartTXLOAD,
    output logic [7:0]        uartTXDATA
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {SCAN, READY, LOAD} state_t;

    state_t          state;
    logic [2:0]      ptr;
    logic [DIVW-1:0] div;
    logic            eligible;

    assign eligible = tcrLIN[ptr] & uartTXEMPTY[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            ptr        <= '0;
            div        <= '0;
            csrTRDY    <= 1'b0;
            csrTLINE   <= '0;
            uartTXLOAD <= '0;
            uartTXDATA <= '0;
        end else if (devRESET || csrCLR) begin
            state      <= SCAN;
            ptr        <= '0;
            div        <= '0;
            csrTRDY    <= 1'b0;
            csrTLINE   <= '0;
            uartTXLOAD <= '0;
            uartTXDATA <= '0;
        end else begin
            uartTXLOAD <= '0;
            case (state)
                SCAN: begin
                    if (!csrMSE) begin
                        div <= '0;
                    end else if (div == DIV_LAST) begin
                        div <= '0;
                        if (eligible) begin
                            state    <= READY;
                            csrTRDY  <= 1'b1;
                            csrTLINE <= ptr;
                        end else begin
                            ptr <= ptr + 3'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                READY: begin
                    // A write in the same cycle as a LIN/MSE drop still loads the byte.
                    if (tdrWRITE && devLOBYTE) begin
                        uartTXLOAD <= NLINES'(1) << csrTLINE;
                        uartTXDATA <= dzDATAI;
                        csrTRDY    <= 1'b0;
                        state      <= LOAD;
                    end else if (!tcrLIN[csrTLINE] || !csrMSE) begin
                        csrTRDY <= 1'b0;
                        ptr     <= csrTLINE + 3'd1;
                        state   <= SCAN;
                    end
                end
                LOAD: begin
                    ptr   <= csrTLINE + 3'd1;
                    div   <= '0;
                    state <= SCAN;
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule
